// File: rtl/video_line_fetch_pkg.sv
// video_line_fetch_pkg
//   Shared video definitions for the scanline fetch path: the packed RGB
//   pixel type, where each colour channel sits inside a 32-bit framebuffer
//   word, the framebuffer pixel stride, and the fetch FSM state encodings.
//   No ports (package).

package video_line_fetch_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Channel positions inside a framebuffer word; bits above PIX_MSB are padding.
    localparam int PIX_MSB   = 23;
    localparam int PIX_R_MSB = 23;
    localparam int PIX_R_LSB = 16;
    localparam int PIX_G_MSB = 15;
    localparam int PIX_G_LSB = 8;
    localparam int PIX_B_MSB = 7;
    localparam int PIX_B_LSB = 0;

    // Each pixel occupies one 32-bit word in system memory.
    localparam int BYTES_PER_PIXEL = 4;

    localparam logic [0:0] FETCH_IDLE = 1'b0;
    localparam logic [0:0] FETCH_REQ  = 1'b1;

    function automatic rgb_t unpack_pixel(input logic [PIX_MSB:0] bits);
        rgb_t px;
        px.r = bits[PIX_R_MSB:PIX_R_LSB];
        px.g = bits[PIX_G_MSB:PIX_G_LSB];
        px.b = bits[PIX_B_MSB:PIX_B_LSB];
        return px;
    endfunction

endpackage

// File: rtl/video_line_ram.sv
// video_line_ram
//   One scanline of pixel storage: a single write port filled by the bus
//   fetch and a synchronous read port addressed by the display column.
//   Ports:
//     i_clock          pixel/bus clock
//     i_write_enable   write strobe
//     i_write_address  pixel index being written
//     i_write_data     pixel colour to store
//     i_read_address   pixel index to read
//     o_read_data      pixel colour, one cycle after i_read_address

import video_line_fetch_pkg::*;

module video_line_ram #(
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic          i_clock,
    input  logic          i_write_enable,
    input  logic [AW-1:0] i_write_address,
    input  rgb_t          i_write_data,
    input  logic [AW-1:0] i_read_address,
    output rgb_t          o_read_data
);

    rgb_t mem [DEPTH];

    // No reset on the storage itself; stale contents are masked by the
    // bank-valid bits in the parent.
    always_ff @(posedge i_clock) begin
        if (i_write_enable) begin
            mem[i_write_address] <= i_write_data;
        end
        o_read_data <= mem[i_read_address];
    end

endmodule

// File: rtl/video_line_fetch.sv
// video_line_fetch
//   Prefetches scanlines from a framebuffer over a simple bus read port into
//   a ping-pong pair of line buffers (line L lives in bank L[0]) and emits
//   RGB pixels aligned with one-cycle-delayed sync/data-enable.
//   Ports:
//     i_clock, i_reset_n           pixel/bus clock, async active-low reset
//     i_hsync, i_vsync, i_vblank   timing generator sync/blank
//     i_data_enable, i_pos_x/y     active-pixel strobe and position
//     i_base                       framebuffer byte address, latched per frame
//     i_clear                      clears the sticky underrun flag
//     o_bus_request/o_bus_address  read request and word-aligned address
//     i_bus_ready/i_bus_rdata      request accepted / pixel word
//     o_hsync, o_vsync, o_data_enable   delayed timing
//     o_rgb                        pixel colour
//     o_underrun                   sticky underrun flag

import video_line_fetch_pkg::*;

module video_line_fetch #(
    parameter int          WIDTH        = 640,
    parameter int          HEIGHT       = 480,
    parameter logic [23:0] UNDERRUN_RGB = 24'hFF00FF
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_vblank,
    input  logic        i_data_enable,
    input  logic [10:0] i_pos_x,
    input  logic [10:0] i_pos_y,
    input  logic [31:0] i_base,
    input  logic        i_clear,
    output logic        o_bus_request,
    output logic [31:0] o_bus_address,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_data_enable,
    output logic [23:0] o_rgb,
    output logic        o_underrun
);

    localparam int          AW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [AW-1:0] LAST_WORD = AW'(WIDTH - 1);
    localparam logic [10:0] LAST_LINE = 11'(HEIGHT - 1);
    localparam logic [31:0] ADDR_STEP = 32'(BYTES_PER_PIXEL);

    logic [0:0]    state;
    logic [AW-1:0] word_count;
    logic          target_bank;
    logic [31:0]   line_addr;
    logic [31:0]   fetch_addr;
    logic [1:0]    valid;

    logic          vblank_d;
    logic          de_d;
    logic          sel_d;
    logic          valid_d;
    logic [10:0]   pos_y_d;
    logic          underrun;

    logic          frame_start;
    logic          line_trigger;
    logic          trigger;
    logic          busy;
    logic          launch_bank;
    logic          accept;
    rgb_t          write_pixel;
    rgb_t          bank0_q;
    rgb_t          bank1_q;
    logic          unused_bits;

    assign unused_bits = &{1'b0, i_pos_x[10:AW], i_bus_rdata[31:PIX_MSB+1]};

    // pos_y_d holds the line that was active when data_enable falls, so the
    // trigger does not depend on when the generator advances i_pos_y.
    assign frame_start  = i_vblank & ~vblank_d;
    assign line_trigger = de_d & ~i_data_enable & (pos_y_d < LAST_LINE);
    assign trigger      = frame_start | line_trigger;
    assign busy         = (state != FETCH_IDLE);
    assign launch_bank  = frame_start ? 1'b0 : ~pos_y_d[0];
    assign accept       = (state == FETCH_REQ) & i_bus_ready;
    assign write_pixel  = unpack_pixel(i_bus_rdata[PIX_MSB:0]);

    assign o_bus_request = (state == FETCH_REQ);
    assign o_bus_address = fetch_addr;

    // Fetch FSM. A trigger that arrives while a fetch is in flight is
    // dropped entirely (only flagged as underrun), so the running fetch and
    // its bank/valid bookkeeping are never disturbed. line_addr advances by
    // accumulation: after the last word, fetch_addr + 4 is the next line.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= FETCH_IDLE;
            word_count  <= '0;
            target_bank <= 1'b0;
            line_addr   <= '0;
            fetch_addr  <= '0;
            valid       <= 2'b00;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (trigger) begin
                        state       <= FETCH_REQ;
                        word_count  <= '0;
                        target_bank <= launch_bank;
                        if (frame_start) begin
                            line_addr  <= i_base;
                            fetch_addr <= i_base;
                            valid      <= 2'b00;
                        end else begin
                            fetch_addr         <= line_addr;
                            valid[launch_bank] <= 1'b0;
                        end
                    end
                end
                FETCH_REQ: begin
                    if (i_bus_ready) begin
                        fetch_addr <= fetch_addr + ADDR_STEP;
                        if (word_count == LAST_WORD) begin
                            state              <= FETCH_IDLE;
                            valid[target_bank] <= 1'b1;
                            line_addr          <= fetch_addr + ADDR_STEP;
                        end else begin
                            word_count <= word_count + 1'b1;
                        end
                    end
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

    // Display-side pipeline: everything here lines up with the registered
    // line-buffer read so o_rgb can be selected combinationally.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_hsync  <= 1'b0;
            o_vsync  <= 1'b0;
            de_d     <= 1'b0;
            vblank_d <= 1'b0;
            pos_y_d  <= '0;
            sel_d    <= 1'b0;
            valid_d  <= 1'b0;
        end else begin
            o_hsync  <= i_hsync;
            o_vsync  <= i_vsync;
            de_d     <= i_data_enable;
            vblank_d <= i_vblank;
            pos_y_d  <= i_pos_y;
            sel_d    <= i_pos_y[0];
            valid_d  <= valid[i_pos_y[0]];
        end
    end

    // Sticky underrun: set has priority over clear.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            underrun <= 1'b0;
        end else if ((i_data_enable & ~valid[i_pos_y[0]]) | (trigger & busy)) begin
            underrun <= 1'b1;
        end else if (i_clear) begin
            underrun <= 1'b0;
        end
    end

    assign o_underrun    = underrun;
    assign o_data_enable = de_d;
    assign o_rgb         = !de_d   ? 24'h000000 :
                           !valid_d ? UNDERRUN_RGB :
                           (sel_d ? bank1_q : bank0_q);

    video_line_ram #(.DEPTH(WIDTH), .AW(AW)) u_bank0 (
        .i_clock         (i_clock),
        .i_write_enable  (accept & ~target_bank),
        .i_write_address (word_count),
        .i_write_data    (write_pixel),
        .i_read_address  (i_pos_x[AW-1:0]),
        .o_read_data     (bank0_q)
    );

    video_line_ram #(.DEPTH(WIDTH), .AW(AW)) u_bank1 (
        .i_clock         (i_clock),
        .i_write_enable  (accept & target_bank),
        .i_write_address (word_count),
        .i_write_data    (write_pixel),
        .i_read_address  (i_pos_x[AW-1:0]),
        .o_read_data     (bank1_q)
    );

endmodule

// File: tb/tb_video_line_fetch.sv
// tb_video_line_fetch
//   Directed bench for video_line_fetch with WIDTH=4, HEIGHT=2. The bus
//   memory returns its own address as data, so pixel n of a line fetched
//   from A reads back as A[23:0] + 4n.

module tb_video_line_fetch;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;

    logic        clock;
    logic        reset_n;
    logic        hsync;
    logic        vsync;
    logic        vblank;
    logic        de;
    logic [10:0] pos_x;
    logic [10:0] pos_y;
    logic [31:0] base;
    logic        clear;
    logic        bus_request;
    logic [31:0] bus_address;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        out_hsync;
    logic        out_vsync;
    logic        out_de;
    logic [23:0] out_rgb;
    logic        underrun;

    int checkCount = 0;
    int errorCount = 0;

    // Bus responder state (written only by the responder process).
    logic [31:0] acceptedQ[$];
    int          stallCnt = 0;
    int          stallErr = 0;
    logic [31:0] heldAddr = '0;

    // Bus responder controls (written only by the main process).
    // 0: ready every cycle, 1: 3 stall cycles per word, 2: accept acceptLimit words.
    int busMode     = 0;
    int limitBase   = 0;
    int acceptLimit = 0;

    logic [23:0] lineRgb [WIDTH];
    logic        lineDe  [WIDTH];
    logic        afterDe;
    logic [23:0] afterRgb;

    video_line_fetch #(
        .WIDTH        (WIDTH),
        .HEIGHT       (HEIGHT),
        .UNDERRUN_RGB (24'hFF00FF)
    ) dut (
        .i_clock       (clock),
        .i_reset_n     (reset_n),
        .i_hsync       (hsync),
        .i_vsync       (vsync),
        .i_vblank      (vblank),
        .i_data_enable (de),
        .i_pos_x       (pos_x),
        .i_pos_y       (pos_y),
        .i_base        (base),
        .i_clear       (clear),
        .o_bus_request (bus_request),
        .o_bus_address (bus_address),
        .i_bus_ready   (bus_ready),
        .i_bus_rdata   (bus_rdata),
        .o_hsync       (out_hsync),
        .o_vsync       (out_vsync),
        .o_data_enable (out_de),
        .o_rgb         (out_rgb),
        .o_underrun    (underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory word at address A holds A.
    assign bus_rdata = bus_address;

    always @(negedge clock) begin
        if (!bus_request) begin
            if (busMode == 1 && stallCnt != 0) stallErr++;
            stallCnt  = 0;
            bus_ready = 1'b0;
        end else begin
            case (busMode)
                0: begin
                    bus_ready = 1'b1;
                    acceptedQ.push_back(bus_address);
                end
                1: begin
                    if (stallCnt == 0) heldAddr = bus_address;
                    else if (bus_address !== heldAddr) stallErr++;
                    if (stallCnt == 3) begin
                        bus_ready = 1'b1;
                        acceptedQ.push_back(bus_address);
                        stallCnt = 0;
                    end else begin
                        bus_ready = 1'b0;
                        stallCnt++;
                    end
                end
                default: begin
                    if (acceptedQ.size() - limitBase < acceptLimit) begin
                        bus_ready = 1'b1;
                        acceptedQ.push_back(bus_address);
                    end else begin
                        bus_ready = 1'b0;
                    end
                end
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one active line on row y, capturing o_rgb per pixel and the
    // first blank cycle after it.
    task automatic applyStimulus(input int y);
        for (int x = 0; x < WIDTH; x++) begin
            de    = 1'b1;
            pos_x = 11'(x);
            pos_y = 11'(y);
            @(posedge clock);
            @(negedge clock);
            lineRgb[x] = out_rgb;
            lineDe[x]  = out_de;
        end
        de    = 1'b0;
        pos_x = '0;
        @(posedge clock);
        @(negedge clock);
        afterDe  = out_de;
        afterRgb = out_rgb;
    endtask

    task automatic checkLine(input string tag, input logic [23:0] first, input logic [23:0] step);
        for (int x = 0; x < WIDTH; x++) begin
            checkOutput($sformatf("%s_px%0d", tag, x), 32'(lineRgb[x]), 32'(first + step * 24'(x)));
            checkOutput($sformatf("%s_de%0d", tag, x), 32'(lineDe[x]), 32'd1);
        end
        checkOutput({tag, "_deOff"}, 32'(afterDe), 32'd0);
        checkOutput({tag, "_rgbOff"}, 32'(afterRgb), 32'd0);
    endtask

    task automatic startFrame(input logic [31:0] frameBase);
        base   = frameBase;
        vblank = 1'b1;
        repeat (2) @(negedge clock);
        vblank = 1'b0;
        @(negedge clock);
    endtask

    task automatic waitFetchDone(input int startIdx, input logic [31:0] firstAddr, input string tag);
        bit done = 0;
        int got;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clock);
            if (acceptedQ.size() - startIdx >= WIDTH && !bus_request) done = 1;
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        repeat (2) @(negedge clock);
        got = acceptedQ.size() - startIdx;
        checkOutput({tag, "_words"}, 32'(got), 32'(WIDTH));
        for (int i = 0; i < WIDTH && i < got; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), acceptedQ[startIdx + i], firstAddr + 32'(4 * i));
        end
        checkOutput({tag, "_reqLow"}, 32'(bus_request), 32'd0);
    endtask

    int idx;
    int stallErrStart;

    initial begin
        reset_n = 1'b0;
        hsync   = 1'b1;
        vsync   = 1'b1;
        vblank  = 1'b0;
        de      = 1'b0;
        pos_x   = '0;
        pos_y   = '0;
        base    = '0;
        clear   = 1'b0;

        repeat (3) @(negedge clock);
        checkOutput("rstReq",  32'(bus_request), 32'd0);
        checkOutput("rstAddr", bus_address,      32'd0);
        checkOutput("rstRgb",  32'(out_rgb),     32'd0);
        checkOutput("rstHs",   32'(out_hsync),   32'd0);
        checkOutput("rstVs",   32'(out_vsync),   32'd0);
        checkOutput("rstDe",   32'(out_de),      32'd0);
        checkOutput("rstUnd",  32'(underrun),    32'd0);

        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("hsDelay", 32'(out_hsync), 32'd1);
        checkOutput("vsDelay", 32'(out_vsync), 32'd1);
        hsync = 1'b0;
        vsync = 1'b0;
        @(negedge clock);
        checkOutput("hsDrop", 32'(out_hsync), 32'd0);

        $display("[TB] frame with ready every cycle");
        busMode = 0;
        idx = acceptedQ.size();
        startFrame(32'h1000);
        waitFetchDone(idx, 32'h1000, "f0l0");
        idx = acceptedQ.size();
        applyStimulus(0);
        checkLine("f0l0", 24'h001000, 24'd4);
        waitFetchDone(idx, 32'h1010, "f0l1");
        applyStimulus(1);
        checkLine("f0l1", 24'h001010, 24'd4);
        idx = acceptedQ.size();
        repeat (6) @(negedge clock);
        checkOutput("lastLineNoFetch", 32'(acceptedQ.size() - idx), 32'd0);
        checkOutput("lastLineReqLow", 32'(bus_request), 32'd0);
        checkOutput("f0Und", 32'(underrun), 32'd0);

        $display("[TB] frame with memory never ready");
        busMode     = 2;
        limitBase   = acceptedQ.size();
        acceptLimit = 0;
        startFrame(32'h3000);
        repeat (4) @(negedge clock);
        checkOutput("stuckReq", 32'(bus_request), 32'd1);
        checkOutput("stuckAddr", bus_address, 32'h3000);
        applyStimulus(0);
        checkLine("f1l0", 24'hFF00FF, 24'd0);
        checkOutput("underrunSet", 32'(underrun), 32'd1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checkOutput("underrunClr", 32'(underrun), 32'd0);
        de    = 1'b1;
        pos_y = 11'd1;
        clear = 1'b1;
        @(negedge clock);
        de    = 1'b0;
        clear = 1'b0;
        checkOutput("setWins", 32'(underrun), 32'd1);
        @(negedge clock);
        pos_y = '0;
        checkOutput("sticky", 32'(underrun), 32'd1);

        $display("[TB] reset mid-fetch");
        acceptLimit = 2;
        repeat (8) @(negedge clock);
        checkOutput("midWords", 32'(acceptedQ.size() - limitBase), 32'd2);
        checkOutput("midAddr", bus_address, 32'h3008);
        checkOutput("midReq", 32'(bus_request), 32'd1);
        hsync = 1'b1;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkOutput("rst2Req",  32'(bus_request), 32'd0);
        checkOutput("rst2Addr", bus_address,      32'd0);
        checkOutput("rst2Und",  32'(underrun),    32'd0);
        checkOutput("rst2Hs",   32'(out_hsync),   32'd0);
        checkOutput("rst2Rgb",  32'(out_rgb),     32'd0);
        busMode = 0;
        hsync   = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        idx = acceptedQ.size();
        startFrame(32'h4000);
        waitFetchDone(idx, 32'h4000, "f2l0");

        $display("[TB] stalled fetch and trigger while busy");
        busMode       = 1;
        stallErrStart = stallErr;
        idx = acceptedQ.size();
        applyStimulus(0);
        checkLine("f2l0", 24'h004000, 24'd4);
        checkOutput("undBeforeBusy", 32'(underrun), 32'd0);
        applyStimulus(0);
        checkOutput("busyReq", 32'(bus_request), 32'd1);
        checkOutput("undBusyTrig", 32'(underrun), 32'd1);
        waitFetchDone(idx, 32'h4010, "f2l1");
        checkOutput("stallStable", 32'(stallErr - stallErrStart), 32'd0);
        applyStimulus(1);
        checkLine("f2l1", 24'h004010, 24'd4);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/video_line_fetch.md
Name: video_line_fetch

Overview:
- Sits directly downstream of the VGA timing generator.
- Consumes the generator's sync, blank, data-enable and pixel-position outputs.
- Prefetches each scanline from a framebuffer in system memory into a ping-pong line buffer over the bus read port.
- Emits RGB pixels aligned with delayed copies of the sync and data-enable signals, ready for the video DAC/HDMI encoder.

Parameters:
- WIDTH, 640, active pixels per line. Must equal the timing generator's HLINE.
- HEIGHT, 480, active lines per frame. Must equal the timing generator's VLINE.
- UNDERRUN_RGB, 24'hFF00FF, colour emitted when the current line is not fully fetched.

Ports:
- i_clock  input  1  pixel clock; also the bus clock.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_hsync  input  1  from timing generator.
- i_vsync  input  1  from timing generator.
- i_vblank  input  1  1 during vertical blank.
- i_data_enable  input  1  1 during active pixel.
- i_pos_x  input  11  active pixel column.
- i_pos_y  input  11  active line.
- i_base  input  32  framebuffer byte address; latched on frame start.
- i_clear  input  1  clears o_underrun.
- o_bus_request  output  1  read request.
- o_bus_address  output  32  word-aligned byte address.
- i_bus_ready  input  1  read data valid / request accepted.
- i_bus_rdata  input  32  pixel word; bits [23:0] = R[23:16] G[15:8] B[7:0].
- o_hsync  output  1  i_hsync delayed 1 cycle.
- o_vsync  output  1  i_vsync delayed 1 cycle.
- o_data_enable  output  1  i_data_enable delayed 1 cycle.
- o_rgb  output  24  pixel colour.
- o_underrun  output  1  sticky error flag.

Behaviour:
- Reset (async, i_reset_n=0):
  - FSM IDLE; o_bus_request=0; o_bus_address=0.
  - Both bank-valid bits 0; all delayed outputs 0; o_rgb=0; o_underrun=0; base register 0.
- Banks:
  - Two line buffers, each WIDTH x 24 bits.
  - Line L is stored in bank L[0]. The display side reads bank i_pos_y[0].
- Frame start = rising edge of i_vblank:
  - Latch i_base into line_addr.
  - Clear both valid bits.
  - Trigger fetch of line 0.
- Line trigger = falling edge of i_data_enable on line L with L < HEIGHT-1:
  - Clear valid[(L+1)[0]].
  - Trigger fetch of line L+1.
  - No trigger on line HEIGHT-1.
- Fetch FSM:
  - IDLE -> REQ on trigger. word counter n=0; target bank latched.
  - REQ: o_bus_request=1, o_bus_address=line_addr + 4*n. Hold both until i_bus_ready=1.
  - On the ready cycle: write rdata[23:0] to bank[n] and increment n.
    - If n==WIDTH-1: deassert request, set valid[bank], line_addr += 4*WIDTH, go to IDLE.
    - Otherwise stay in REQ with the new address; request may stay asserted back-to-back.
- Trigger while FSM not IDLE:
  - Ignored.
  - o_underrun set.
  - The in-flight fetch completes normally.
- Output, 1-cycle latency:
  - The line buffer is read synchronously at i_pos_x.
  - o_rgb = valid[i_pos_y[0]] sampled with the read ? buffer data : UNDERRUN_RGB.
  - o_rgb = 0 when the delayed data_enable is 0.
- Underrun:
  - i_data_enable=1 while valid[i_pos_y[0]]=0 sets o_underrun.
  - i_clear=1 clears it.
  - A set and a clear in the same cycle: set wins.
- Address arithmetic: 32-bit, wrap modulo 2^32, no multiplier (running accumulator).

Decomposition:
- Shared video package:
  - rgb_t (24-bit struct of r, g, b).
  - Pixel word bit positions.
  - Constant BYTES_PER_PIXEL=4.
- One natural sub-module: video_line_ram.
  - Dual-port, 1 write port, 1 synchronous read port, WIDTH x 24.
  - Instantiated twice.

Test Plan (WIDTH=4, HEIGHT=2, bus memory word at addr A = A):
- Frame start with i_base=0x1000, ready every cycle:
  - Required addresses: 0x1000, 0x1004, 0x1008, 0x100C.
  - Then request drops and valid[0]=1.
- End of line 0: fetch addresses 0x1010 to 0x101C into bank 1. Line 1 displays o_rgb 0x001010 to 0x00101C, one cycle after i_data_enable.
- Ready stalled 3 cycles per word: address and request held stable during each stall; no duplicate writes.
- Memory never ready: line 0 shows 0xFF00FF on all 4 pixels; o_underrun=1; after i_clear pulse o_underrun=0.
- Reset asserted mid-fetch (n=2): request drops immediately; all outputs 0. After release the next frame start refetches from i_base.
- A line trigger arriving while the FSM is busy sets o_underrun; the current fetch still finishes with 4 words.
